// File: rtl/register_writeback_queue.sv
// register_writeback_queue: in-order queue of in-flight destination tags; retiring the oldest tag
// drives a one-cycle registered clear strobe into the register stall table.
module register_writeback_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2,
  parameter int REG_W = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_W-1:0]      alloc_reg,
  input  logic                  alloc_valid,
  output logic                  alloc_ready,
  input  logic                  retire_valid,
  input  logic                  flush,
  output logic [REG_W-1:0]      wb_reg,
  output logic                  wb_is_valid,
  output logic [2**REG_W-1:0]   pending_mask,
  output logic [PTR_W:0]        count,
  output logic                  underflow_err
);
  logic [REG_W-1:0] tag_q [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [REG_W-1:0] wb_reg_q, wb_reg_d;
  logic             wb_vld_q, wb_vld_d, uf_q, uf_d;
  logic             push, pop;
  assign alloc_ready   = count_q != (PTR_W+1)'(DEPTH);
  assign push          = alloc_valid & alloc_ready & ~flush;
  assign pop           = retire_valid & (count_q != '0) & ~flush;
  assign wb_reg        = wb_reg_q;
  assign wb_is_valid   = wb_vld_q;
  assign count         = count_q;
  assign underflow_err = uf_q;
  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < DEPTH; i++)
      if (vld_q[i]) pending_mask[tag_q[i]] = 1'b1;
  end
  always_comb begin
    vld_d    = vld_q;
    if (pop) vld_d[rd_ptr_q] = 1'b0;
    if (push) vld_d[wr_ptr_q] = 1'b1;
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = (push && !pop) ? count_q + 1'b1 : (pop && !push) ? count_q - 1'b1 : count_q;
    wb_reg_d = pop ? tag_q[rd_ptr_q] : wb_reg_q;
    wb_vld_d = pop;
    uf_d     = uf_q | (retire_valid & (count_q == '0));
    // Flush discards everything in flight but keeps the sticky underflow record.
    if (flush) begin
      vld_d    = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      wb_reg_q <= '0;
      wb_vld_q <= 1'b0;
      uf_q     <= 1'b0;
    end else begin
      vld_q    <= vld_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      wb_reg_q <= wb_reg_d;
      wb_vld_q <= wb_vld_d;
      uf_q     <= uf_d;
    end
  end
  always_ff @(posedge clk)
    if (push) tag_q[wr_ptr_q] <= alloc_reg;
endmodule

// File: tb/tb_register_writeback_queue.sv
// tb_register_writeback_queue: directed stimulus with a scoreboard of expected clear pulses
// checked by an independent monitor.
module tb_register_writeback_queue;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] alloc_reg = '0;
  logic       alloc_valid = 1'b0, retire_valid = 1'b0, flush = 1'b0;
  logic       alloc_ready, wb_is_valid, underflow_err;
  logic [2:0] wb_reg;
  logic [7:0] pending_mask;
  logic [2:0] count;
  int checks = 0, errors = 0, cyc = 0;
  typedef struct { logic [2:0] tag; int cyc; } exp_t;
  exp_t sb[$];

  register_writeback_queue #(.DEPTH(4), .PTR_W(2), .REG_W(3)) dut (
    .clk(clk), .reset(reset), .alloc_reg(alloc_reg), .alloc_valid(alloc_valid),
    .alloc_ready(alloc_ready), .retire_valid(retire_valid), .flush(flush),
    .wb_reg(wb_reg), .wb_is_valid(wb_is_valid), .pending_mask(pending_mask),
    .count(count), .underflow_err(underflow_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    if (wb_is_valid) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL wb_unexpected: pulse tag %0d at cycle %0d, none expected", wb_reg, cyc);
      end else begin
        e = sb.pop_front();
        if (wb_reg !== e.tag || cyc != e.cyc) begin
          errors++;
          $display("FAIL wb_pulse: got tag %0d at cycle %0d, expected tag %0d at cycle %0d",
                   wb_reg, cyc, e.tag, e.cyc);
        end
      end
    end else if (sb.size() != 0 && sb[0].cyc <= cyc) begin
      checks++;
      errors++;
      e = sb.pop_front();
      $display("FAIL wb_missing: no pulse at cycle %0d, expected tag %0d", cyc, e.tag);
    end
  end

  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", n, act, exp);
    end
  endtask

  task automatic step(input logic av, input logic [2:0] t, input logic rv, input logic fl,
                      input logic ep, input logic [2:0] et);
    alloc_valid = av; alloc_reg = t; retire_valid = rv; flush = fl;
    if (ep) sb.push_back('{et, cyc + 1});
    @(negedge clk);
    alloc_valid = 1'b0; retire_valid = 1'b0; flush = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_count", count, 0);
    chk("rst_mask", pending_mask, 0);
    chk("rst_ready", alloc_ready, 1);
    chk("rst_wbv", wb_is_valid, 0);
    chk("rst_uf", underflow_err, 0);
    reset = 1'b1;
    @(negedge clk);
    // push 0,1,2
    step(1, 0, 0, 0, 0, 0); step(1, 1, 0, 0, 0, 0); step(1, 2, 0, 0, 0, 0);
    chk("p3_count", count, 3);
    chk("p3_mask", pending_mask, 8'h07);
    chk("p3_ready", alloc_ready, 1);
    chk("p3_wbv", wb_is_valid, 0);
    step(0, 0, 1, 0, 1, 0); step(0, 0, 1, 0, 1, 1); step(0, 0, 1, 0, 1, 2);
    chk("drain_count", count, 0);
    chk("drain_mask", pending_mask, 0);
    // fill with duplicate tag, then overflow push
    step(1, 5, 0, 0, 0, 0); step(1, 5, 0, 0, 0, 0); step(1, 6, 0, 0, 0, 0); step(1, 7, 0, 0, 0, 0);
    chk("full_count", count, 4);
    chk("full_ready", alloc_ready, 0);
    chk("full_mask", pending_mask, 8'hE0);
    step(1, 3, 0, 0, 0, 0);
    chk("ovf_count", count, 4);
    chk("ovf_mask", pending_mask, 8'hE0);
    step(0, 0, 1, 0, 1, 5);
    chk("dup1_mask", pending_mask, 8'hE0);
    chk("dup1_ready", alloc_ready, 1);
    step(0, 0, 1, 0, 1, 5);
    chk("dup2_mask", pending_mask, 8'hC0);
    step(0, 0, 1, 0, 1, 6);
    chk("r6_mask", pending_mask, 8'h80);
    step(0, 0, 1, 0, 1, 7);
    chk("r7_mask", pending_mask, 8'h00);
    chk("r7_count", count, 0);
    // wrap-around: 10 push/retire pairs, tags 0..7,0,1
    for (int i = 0; i < 10; i++) begin
      step(1, 3'(i), 0, 0, 0, 0);
      chk("wrap_count1", count, 1);
      step(0, 0, 1, 0, 1, 3'(i));
      chk("wrap_count0", count, 0);
    end
    // simultaneous push of 4 and retire at count=2 holding {1,2}
    step(1, 1, 0, 0, 0, 0); step(1, 2, 0, 0, 0, 0);
    step(1, 4, 1, 0, 1, 1);
    chk("sim_count", count, 2);
    chk("sim_mask", pending_mask, 8'h14);
    chk("sim_wbv", wb_is_valid, 1);
    chk("sim_wbreg", wb_reg, 1);
    step(0, 0, 1, 0, 1, 2); step(0, 0, 1, 0, 1, 4);
    // retire on empty queue; push alongside is accepted without bypass
    chk("pre_uf", underflow_err, 0);
    step(1, 6, 1, 0, 0, 0);
    chk("uf_set", underflow_err, 1);
    chk("uf_wbv", wb_is_valid, 0);
    chk("uf_count", count, 1);
    step(0, 0, 1, 0, 1, 6);
    step(1, 3, 0, 0, 0, 0); step(0, 0, 1, 0, 1, 3);
    chk("uf_sticky", underflow_err, 1);
    // flush with count=3 plus simultaneous push/retire
    step(1, 1, 0, 0, 0, 0); step(1, 2, 0, 0, 0, 0); step(1, 3, 0, 0, 0, 0);
    step(1, 5, 1, 1, 0, 0);
    chk("fl_count", count, 0);
    chk("fl_mask", pending_mask, 0);
    chk("fl_ready", alloc_ready, 1);
    chk("fl_wbv", wb_is_valid, 0);
    chk("fl_uf", underflow_err, 1);
    step(0, 0, 0, 0, 0, 0);
    chk("fl_wbv2", wb_is_valid, 0);
    // async reset between edges with a retire pending
    step(1, 1, 0, 0, 0, 0); step(1, 2, 0, 0, 0, 0); step(1, 3, 0, 0, 0, 0);
    chk("ar_pre_count", count, 3);
    retire_valid = 1'b1;
    #2 reset = 1'b0;
    #1;
    chk("ar_count", count, 0);
    chk("ar_mask", pending_mask, 0);
    chk("ar_uf", underflow_err, 0);
    chk("ar_wbv", wb_is_valid, 0);
    chk("ar_ready", alloc_ready, 1);
    @(negedge clk);
    retire_valid = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("ar_post_wbv", wb_is_valid, 0);
    chk("ar_post_count", count, 0);
    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
